// File: rtl/relu_pkg.sv
// Shared definitions for activation stages: default word width and the
// rectification function reused by other activation blocks.
package relu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  // Widest word the shared function handles; callers zero-extend into it.
  localparam int unsigned MAX_W = 64;

  typedef logic [DATA_W_DEF-1:0] word_t;

  // Rectify a word given its sign bit and its zero-extended bit pattern;
  // positive results are optionally clipped to clip_max.
  function automatic logic [MAX_W-1:0] relu_f(
    input logic             neg,
    input logic [MAX_W-1:0] mag,
    input logic             clip_en,
    input logic [MAX_W-1:0] clip_max
  );
    logic [MAX_W-1:0] res;
    res = mag;
    if (neg) begin
      res = '0;
    end else if (clip_en && (mag > clip_max)) begin
      res = clip_max;
    end
    return res;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: an output register plus one skid
// register, so in_ready is registered and never depends on out_ready.
module skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_fire_c;
  logic             out_free_c;

  assign in_fire_c  = in_valid && !skid_valid_q;
  assign out_free_c = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free_c) begin
      // Skid word takes priority so order is preserved.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire_c) begin
        out_d       = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire_c) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/relu_unit.sv
// Streaming ReLU / ReLU-N stage: rectifies on the input side and registers
// the result through a two-entry skid buffer.
module relu_unit
  import relu_pkg::*;
#(
  parameter int unsigned     DATA_W   = DATA_W_DEF,
  parameter bit              CLIP_EN  = 1'b0,
  parameter longint unsigned CLIP_MAX = 64'd6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_relu,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout_relu,
  output logic              dout_valid,
  input  logic              dout_ready
);

  logic [DATA_W-1:0] relu_c;

  assign relu_c = DATA_W'(relu_f(din_relu[DATA_W-1], MAX_W'(din_relu),
                                 CLIP_EN, MAX_W'(CLIP_MAX)));

  skid_buffer #(
    .WIDTH(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (relu_c),
    .in_valid (din_valid),
    .in_ready (din_ready),
    .out_data (dout_relu),
    .out_valid(dout_valid),
    .out_ready(dout_ready)
  );

endmodule

// File: tb/tb_relu_unit.sv
// Directed self-checking bench for relu_unit: one plain instance and one
// ReLU-6 instance share the same stimulus and handshake inputs.
module tb_relu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din_relu;
  logic        din_valid;
  logic        dout_ready;
  logic        din_ready0, dout_valid0, din_ready1, dout_valid1;
  logic [31:0] dout_relu0, dout_relu1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_q[$];
  int unsigned n_out;

  always #5 clk = ~clk;

  relu_unit #(.DATA_W(32), .CLIP_EN(1'b0), .CLIP_MAX(64'd6)) dut0 (
    .clk(clk), .rst(rst), .din_relu(din_relu), .din_valid(din_valid),
    .din_ready(din_ready0), .dout_relu(dout_relu0), .dout_valid(dout_valid0),
    .dout_ready(dout_ready)
  );

  relu_unit #(.DATA_W(32), .CLIP_EN(1'b1), .CLIP_MAX(64'd6)) dut1 (
    .clk(clk), .rst(rst), .din_relu(din_relu), .din_valid(din_valid),
    .din_ready(din_ready1), .dout_relu(dout_relu1), .dout_valid(dout_valid1),
    .dout_ready(dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One word at full throughput; both instances checked one edge later.
  task automatic stream_one(input logic [31:0] x, input logic [31:0] e0, input logic [31:0] e1);
    din_relu  = x;
    din_valid = 1'b1;
    @(posedge clk); #1;
    check("plain_data", dout_relu0, e0);
    check("plain_valid", {31'd0, dout_valid0}, 32'd1);
    check("clip_data", dout_relu1, e1);
    check("clip_valid", {31'd0, dout_valid1}, 32'd1);
  endtask

  // One clock with scoreboard tracking of the plain instance.
  task automatic tick(output logic acc);
    logic        drn, held;
    logic [31:0] prev;
    acc  = din_valid && din_ready0;
    drn  = dout_valid0 && dout_ready;
    held = dout_valid0 && !dout_ready;
    prev = dout_relu0;
    if (drn) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, dout_valid0}, 32'd0);
      end else begin
        check("order", dout_relu0, exp_q[0]);
        void'(exp_q.pop_front());
        n_out++;
      end
    end
    @(posedge clk); #1;
    if (acc) exp_q.push_back(din_relu);
    if (held) begin
      check("hold_data", dout_relu0, prev);
      check("hold_valid", {31'd0, dout_valid0}, 32'd1);
    end
    check("din_ready", {31'd0, din_ready0}, {31'd0, exp_q.size() != 2});
    check("dout_valid", {31'd0, dout_valid0}, {31'd0, exp_q.size() != 0});
  endtask

  initial begin
    logic        acc;
    logic [31:0] pt_vec[8];
    logic [31:0] ex_in[4], ex_e0[4], ex_e1[4];
    logic [31:0] cl_in[5], cl_e1[5];
    logic [15:0] rdy_pat;
    int unsigned word, n_acc;

    rst = 1'b1; din_relu = '0; din_valid = 1'b0; dout_ready = 1'b0;
    n_out = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, dout_valid0}, 32'd0);
    check("rst_data", dout_relu0, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_din_ready", {31'd0, din_ready0}, 32'd1);

    // Passthrough at full rate.
    dout_ready = 1'b1;
    pt_vec = '{32'd0, 32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 32'd4};
    foreach (pt_vec[i]) stream_one(pt_vec[i], pt_vec[i], pt_vec[i]);

    // Negatives and extremes.
    ex_in = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    ex_e0 = '{32'd0, 32'd0, 32'h7FFF_FFFF, 32'd0};
    ex_e1 = '{32'd0, 32'd0, 32'd6, 32'd0};
    foreach (ex_in[i]) stream_one(ex_in[i], ex_e0[i], ex_e1[i]);

    // Clipping to 6.
    cl_in = '{32'd5, 32'd6, 32'd7, 32'd1000, 32'hFFFF_FFFD};
    cl_e1 = '{32'd5, 32'd6, 32'd6, 32'd6, 32'd0};
    foreach (cl_in[i]) stream_one(cl_in[i], cl_in[i] > 32'h7FFF_FFFF ? 32'd0 : cl_in[i], cl_e1[i]);

    din_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", {31'd0, dout_valid0}, 32'd0);

    // Backpressure: 10 words with a fixed irregular ready pattern.
    rdy_pat = 16'b1011_0010_0110_1101;
    word = 0; n_out = 0;
    for (int c = 0; c < 200 && n_out < 10; c++) begin
      dout_ready = rdy_pat[c % 16];
      din_valid  = (word < 10);
      din_relu   = 32'd100 + word;
      tick(acc);
      if (acc) word++;
    end
    check("bp_all_out", n_out, 32'd10);

    // Stall three cycles, then release: two buffered, no bubble after.
    din_valid = 1'b0; dout_ready = 1'b1;
    for (int c = 0; c < 5 && exp_q.size() != 0; c++) tick(acc);
    word = 0; n_acc = 0; dout_ready = 1'b0; din_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      din_relu = 32'd200 + word;
      tick(acc);
      if (acc) begin word++; n_acc++; end
    end
    check("stall_buffered", n_acc, 32'd2);
    dout_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      din_relu = 32'd200 + word;
      tick(acc);
      if (acc) word++;
      check("no_bubble", {31'd0, dout_valid0}, 32'd1);
    end

    // Reset mid-stream with both entries occupied.
    dout_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      din_relu = 32'd200 + word;
      tick(acc);
      if (acc) word++;
    end
    check("pre_rst_full", {31'd0, din_ready0}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, dout_valid0}, 32'd0);
    check("async_rst_data", dout_relu0, 32'd0);
    exp_q.delete();
    din_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_din_ready", {31'd0, din_ready0}, 32'd1);
    check("post_rst_valid", {31'd0, dout_valid0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
